// File: rtl/rst_pkg.sv
// Shared constants and types for the register status table.
package rst_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_TAG_W    = 6;
  localparam int DEF_NUM_CDB  = 2;
  localparam int DEF_NUM_RD   = 2;
  localparam int REG_AW       = $clog2(DEF_NUM_REGS);
  localparam int CNT_W        = REG_AW + 1;

  typedef struct packed {
    logic                 pend;
    logic [DEF_TAG_W-1:0] tag;
  } rst_entry_t;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/rst_cdb_match.sv
// One CDB port against the whole table: raw hit vector plus lowest-index writeback steering.
module rst_cdb_match
  import rst_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic [NUM_REGS-1:0]            pend,
  input  logic [NUM_REGS-1:0][TAG_W-1:0] tags,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  output logic [NUM_REGS-1:0]            hit,
  output logic [$clog2(NUM_REGS)-1:0]    wb_rd,
  output logic                           wb_en
);
  localparam int AW = $clog2(NUM_REGS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_hit
      assign hit[gi] = cdb_valid && pend[gi] && (tags[gi] == cdb_tag);
    end
  endgenerate

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    wb_rd = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (hit[i]) wb_rd = AW'(i);
    end
  end

  assign wb_en = |hit;
endmodule

// File: rtl/rst_multi_cdb.sv
// Register status table: rename writes, multi-port CDB wakeup with bypassed lookups, flush and pending count.
module rst_multi_cdb
  import rst_pkg::*;
#(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int NUM_CDB     = DEF_NUM_CDB,
  parameter int NUM_RD      = DEF_NUM_RD,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic                                         disp_wen,
  input  logic [$clog2(NUM_REGS)-1:0]                  disp_waddr,
  input  logic [TAG_W-1:0]                             disp_wtag,
  input  logic [NUM_RD-1:0][$clog2(NUM_REGS)-1:0]      rd_addr,
  output logic [NUM_RD-1:0][TAG_W-1:0]                 rd_tag,
  output logic [NUM_RD-1:0]                            rd_pending,
  input  logic [NUM_CDB-1:0]                           cdb_valid,
  input  logic [NUM_CDB-1:0][TAG_W-1:0]                cdb_tag,
  output logic [NUM_CDB-1:0][$clog2(NUM_REGS)-1:0]     wb_rd,
  output logic [NUM_CDB-1:0]                           wb_en,
  output logic [$clog2(NUM_REGS):0]                    pending_cnt
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = AW + 1;

  logic [NUM_REGS-1:0]            pend_q, pend_d;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0]                  cnt_q, cnt_d;

  logic [NUM_CDB-1:0][NUM_REGS-1:0] hit_vec;
  logic [NUM_REGS-1:0]              clear_mask;
  logic                             write_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CDB; gi++) begin : g_cdb
      rst_cdb_match #(
        .NUM_REGS (NUM_REGS),
        .TAG_W    (TAG_W)
      ) u_match (
        .pend      (pend_q),
        .tags      (tag_q),
        .cdb_valid (cdb_valid[gi]),
        .cdb_tag   (cdb_tag[gi]),
        .hit       (hit_vec[gi]),
        .wb_rd     (wb_rd[gi]),
        .wb_en     (wb_en[gi])
      );
    end
  endgenerate

  always_comb begin
    clear_mask = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      clear_mask = clear_mask | hit_vec[k];
    end
  end

  assign write_ok = disp_wen && !(ZERO_REG_EN && (disp_waddr == '0));

  // Priority low to high: CDB clear, then rename write, then flush.
  always_comb begin
    pend_d = pend_q & ~clear_mask;
    tag_d  = tag_q;
    if (write_ok) begin
      pend_d[disp_waddr] = 1'b1;
      tag_d[disp_waddr]  = disp_wtag;
    end
    if (flush) pend_d = '0;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CW'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  // Lookups read the pre-edge table; a same-cycle broadcast already counts as resolved.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign rd_pending[gi] = pend_q[rd_addr[gi]] && !clear_mask[rd_addr[gi]] &&
                              !(ZERO_REG_EN && (rd_addr[gi] == '0));
      assign rd_tag[gi]     = rd_pending[gi] ? tag_q[rd_addr[gi]] : '0;
    end
  endgenerate

  assign pending_cnt = cnt_q;
endmodule

// File: tb/tb_rst_multi_cdb.sv
// Directed bench: stimulus pushes expectations into queues, a negedge monitor pops and compares.
module tb_rst_multi_cdb;
  logic            clk;
  logic            rst;
  logic            flush;
  logic            disp_wen;
  logic [4:0]      disp_waddr;
  logic [5:0]      disp_wtag;
  logic [1:0][4:0] rd_addr;
  logic [1:0][5:0] rd_tag;
  logic [1:0]      rd_pending;
  logic [1:0]      cdb_valid;
  logic [1:0][5:0] cdb_tag;
  logic [1:0][4:0] wb_rd;
  logic [1:0]      wb_en;
  logic [5:0]      pending_cnt;

  rst_multi_cdb dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .disp_wen    (disp_wen),
    .disp_waddr  (disp_waddr),
    .disp_wtag   (disp_wtag),
    .rd_addr     (rd_addr),
    .rd_tag      (rd_tag),
    .rd_pending  (rd_pending),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .wb_rd       (wb_rd),
    .wb_en       (wb_en),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_TAG0 = 0, S_PEND0 = 1, S_TAG1 = 2, S_PEND1 = 3;
  localparam int S_WBEN0 = 4, S_WBRD0 = 5, S_WBEN1 = 6, S_WBRD1 = 7, S_CNT = 8;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    int cyc;
    int port;
    int rd;
  } wb_t;

  chk_t chk_q[$];
  wb_t  wb_q[$];
  int   cur = 0;
  bit   done = 1'b0;
  int   checks = 0;
  int   failures = 0;
  chk_t c;
  wb_t  w;

  function automatic logic [31:0] get_act(input int sel);
    case (sel)
      S_TAG0:  return 32'(rd_tag[0]);
      S_PEND0: return 32'(rd_pending[0]);
      S_TAG1:  return 32'(rd_tag[1]);
      S_PEND1: return 32'(rd_pending[1]);
      S_WBEN0: return 32'(wb_en[0]);
      S_WBRD0: return 32'(wb_rd[0]);
      S_WBEN1: return 32'(wb_en[1]);
      S_WBRD1: return 32'(wb_rd[1]);
      default: return 32'(pending_cnt);
    endcase
  endfunction

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    flush      = 1'b0;
    disp_wen   = 1'b0;
    disp_waddr = '0;
    disp_wtag  = '0;
    cdb_valid  = '0;
    cdb_tag    = '0;
    rd_addr    = '0;
    cur++;
  endtask

  task automatic ex(input int sel, input int val, input string name);
    chk_t e;
    e.cyc  = cur;
    e.sel  = sel;
    e.exp  = 32'(val);
    e.name = name;
    chk_q.push_back(e);
  endtask

  task automatic ex_wb(input int port, input int rd);
    wb_t e;
    e.cyc  = cur;
    e.port = port;
    e.rd   = rd;
    wb_q.push_back(e);
  endtask

  task automatic rename(input int r, input int t);
    disp_wen   = 1'b1;
    disp_waddr = 5'(r);
    disp_wtag  = 6'(t);
  endtask

  task automatic bcast(input int port, input int t);
    cdb_valid[port] = 1'b1;
    cdb_tag[port]   = 6'(t);
  endtask

  // Monitor: scalar checks for this cycle, then every asserted wb_en against the writeback queue.
  always @(negedge clk) begin
    while (chk_q.size() > 0 && chk_q[0].cyc <= cur) begin
      c = chk_q.pop_front();
      checks++;
      if (c.cyc != cur || get_act(c.sel) !== c.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", c.name, c.cyc, get_act(c.sel), c.exp);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (wb_en[k] === 1'b1) begin
        checks++;
        if (wb_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected cyc=%0d port=%0d actual_rd=%0d required=none", cur, k, wb_rd[k]);
        end else begin
          w = wb_q.pop_front();
          if (w.cyc != cur || w.port != k || 32'(wb_rd[k]) != 32'(w.rd)) begin
            failures++;
            $display("FAIL wb_event cyc=%0d actual=port%0d/rd%0d required=cyc%0d/port%0d/rd%0d",
                     cur, k, wb_rd[k], w.cyc, w.port, w.rd);
          end
        end
      end
    end
    if (done) begin
      checks++;
      if (chk_q.size() != 0 || wb_q.size() != 0) begin
        failures++;
        $display("FAIL leftover actual=%0d/%0d required=0/0", chk_q.size(), wb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    disp_wen   = 1'b0;
    disp_waddr = '0;
    disp_wtag  = '0;
    cdb_valid  = '0;
    cdb_tag    = '0;
    rd_addr    = '0;

    cyc_begin();
    ex(S_PEND0, 0, "rst_pend"); ex(S_TAG0, 0, "rst_tag"); ex(S_WBEN0, 0, "rst_wben0");
    ex(S_WBRD0, 0, "rst_wbrd0"); ex(S_WBEN1, 0, "rst_wben1"); ex(S_CNT, 0, "rst_cnt");

    cyc_begin(); rst = 1'b0;
    rename(5, 'h12); rd_addr[0] = 5;
    ex(S_PEND0, 0, "r5_old_view"); ex(S_CNT, 0, "cnt_before_r5");

    cyc_begin(); rd_addr[0] = 5;
    ex(S_PEND0, 1, "r5_pend"); ex(S_TAG0, 'h12, "r5_tag"); ex(S_CNT, 1, "cnt_r5");

    cyc_begin(); rd_addr[0] = 5; bcast(0, 'h12);
    ex_wb(0, 5);
    ex(S_WBEN0, 1, "cdb0_wben"); ex(S_WBRD0, 5, "cdb0_wbrd"); ex(S_PEND0, 0, "r5_bypass");
    ex(S_TAG0, 0, "r5_bypass_tag"); ex(S_WBEN1, 0, "cdb1_idle"); ex(S_CNT, 1, "cnt_during_clear");

    cyc_begin(); rd_addr[0] = 5;
    ex(S_PEND0, 0, "r5_cleared"); ex(S_CNT, 0, "cnt_after_clear"); ex(S_WBEN0, 0, "wben0_idle");

    cyc_begin(); rename(7, 'h03);

    cyc_begin(); rename(7, 'h04); bcast(1, 'h03); rd_addr[1] = 7;
    ex_wb(1, 7);
    ex(S_WBEN1, 1, "race_wben1"); ex(S_WBRD1, 7, "race_wbrd1"); ex(S_PEND1, 0, "race_bypass");
    ex(S_CNT, 1, "race_cnt_before");

    cyc_begin(); rd_addr[1] = 7; rename(2, 'h01); rd_addr[0] = 2;
    ex(S_PEND1, 1, "race_new_pend"); ex(S_TAG1, 'h04, "race_new_tag"); ex(S_CNT, 1, "race_cnt_after");
    ex(S_PEND0, 0, "r2_old_view");

    cyc_begin(); rename(9, 'h02);
    ex(S_CNT, 2, "cnt_r7_r2");

    cyc_begin(); bcast(0, 'h02); bcast(1, 'h01); rd_addr[0] = 9; rd_addr[1] = 2;
    ex_wb(0, 9); ex_wb(1, 2);
    ex(S_CNT, 3, "cnt_three"); ex(S_WBEN0, 1, "dual_wben0"); ex(S_WBRD0, 9, "dual_wbrd0");
    ex(S_WBEN1, 1, "dual_wben1"); ex(S_WBRD1, 2, "dual_wbrd1");
    ex(S_PEND0, 0, "dual_bypass0"); ex(S_PEND1, 0, "dual_bypass1");

    cyc_begin(); rd_addr[0] = 9; rd_addr[1] = 7; rename(0, 'h3F);
    ex(S_CNT, 1, "dual_cnt_drop"); ex(S_PEND0, 0, "r9_cleared"); ex(S_PEND1, 1, "r7_still");
    ex(S_TAG1, 'h04, "r7_tag_still");

    cyc_begin(); rd_addr[0] = 0; bcast(0, 'h2A);
    ex(S_PEND0, 0, "r0_never"); ex(S_TAG0, 0, "r0_tag"); ex(S_CNT, 1, "r0_cnt");
    ex(S_WBEN0, 0, "nomatch_wben"); ex(S_WBRD0, 0, "nomatch_wbrd");

    cyc_begin(); bcast(0, 'h04); bcast(1, 'h04);
    ex_wb(0, 7); ex_wb(1, 7);
    ex(S_WBRD0, 7, "same_tag_rd0"); ex(S_WBRD1, 7, "same_tag_rd1"); ex(S_CNT, 1, "same_tag_cnt");

    cyc_begin(); rename(1, 'h10);
    ex(S_CNT, 0, "same_tag_single_clear");

    cyc_begin(); rename(3, 'h11);
    ex(S_CNT, 1, "cnt_r1");

    cyc_begin(); rename(6, 'h12);
    ex(S_CNT, 2, "cnt_r1_r3");

    cyc_begin(); flush = 1'b1; rename(4, 'h20); bcast(0, 'h10); rd_addr[0] = 1; rd_addr[1] = 3;
    ex_wb(0, 1);
    ex(S_CNT, 3, "pre_flush_cnt"); ex(S_WBEN0, 1, "flush_wben"); ex(S_WBRD0, 1, "flush_wbrd");
    ex(S_PEND0, 0, "flush_bypass"); ex(S_PEND1, 1, "r3_pre_flush"); ex(S_TAG1, 'h11, "r3_tag");

    cyc_begin(); rd_addr[0] = 4; rd_addr[1] = 3; rename(8, 'h05);
    ex(S_PEND0, 0, "flush_beats_write"); ex(S_PEND1, 0, "flush_r3"); ex(S_CNT, 0, "flush_cnt");

    cyc_begin(); rename(10, 'h06); rd_addr[0] = 8;
    ex(S_PEND0, 1, "r8_pend"); ex(S_TAG0, 'h05, "r8_tag"); ex(S_CNT, 1, "cnt_r8");

    cyc_begin(); rd_addr[0] = 8;
    ex(S_CNT, 2, "cnt_pre_rst"); ex(S_PEND0, 1, "r8_pre_rst");

    cyc_begin(); rst = 1'b1; rd_addr[0] = 8; rd_addr[1] = 10;
    ex(S_PEND0, 0, "async_rst_pend0"); ex(S_TAG0, 0, "async_rst_tag0");
    ex(S_PEND1, 0, "async_rst_pend1"); ex(S_CNT, 0, "async_rst_cnt");

    cyc_begin(); rst = 1'b0; rd_addr[0] = 8;
    ex(S_PEND0, 0, "post_rst_pend"); ex(S_CNT, 0, "post_rst_cnt");

    cyc_begin();
    cyc_begin();
    done = 1'b1;
  end
endmodule
